// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control unit: opcode and state
// encodings, R-type funct codes and ALU operation codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'h0,
    OP_LW    = 4'h1,
    OP_SW    = 4'h2,
    OP_BEQ   = 4'h3,
    OP_ADDI  = 4'h4,
    OP_J     = 4'h5,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_STOP   = 3'd6
  } state_e;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_AND = 3'b010;
  localparam logic [2:0] FN_OR  = 3'b011;
  localparam logic [2:0] FN_SLT = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic is_mem_op(input opcode_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_fsm_aludec.sv
// ALU decoder: maps opcode/funct to the 3-bit ALU operation and flags R-type
// funct codes that have no defined operation.
module aludec
  import ctrl_pkg::*;
(
  input  opcode_e    op,
  input  logic [2:0] funct,
  output logic [2:0] alucontrol,
  output logic       bad_funct
);

  always_comb begin
    alucontrol = ALU_ADD;
    bad_funct  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: bad_funct  = 1'b1;
        endcase
      end
      OP_BEQ:  alucontrol = ALU_SUB;
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multicycle control FSM: fetch over req/ready, then decode/exec/mem/wb strobes.
// Define CTRL_FSM_PERF_CNT_EN to add cycle and retired-instruction counters.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int IWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IWIDTH-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic              imem_req,
  output logic [IWIDTH-1:0] instr,
  input  logic              zero,
  output logic              pcen,
  output logic              memtoreg,
  output logic              pcsrc,
  output logic              alusrc,
  output logic              regdst,
  output logic              regwrite,
  output logic              jump,
  output logic [2:0]        alucontrol,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ready,
  output logic              halted,
  output logic              illegal
`ifdef CTRL_FSM_PERF_CNT_EN
  ,
  output logic [15:0]       cycle_cnt,
  output logic [15:0]       instret_cnt
`endif
);

  state_e            state;
  state_e            state_n;
  logic [IWIDTH-1:0] ir;
  logic              ir_load;
  logic              set_illegal;
  opcode_e           op;
  logic [2:0]        alu_sel;
  logic              bad_funct;

  assign op    = opcode_e'(ir[IWIDTH-1 -: 4]);
  assign instr = ir;

  aludec u_aludec (
    .op         (op),
    .funct      (ir[2:0]),
    .alucontrol (alu_sel),
    .bad_funct  (bad_funct)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (ir_load) ir <= imem_rdata;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  // Strobes depend only on state and ir, except the handshake-qualified pcen
  always_comb begin
    state_n     = state;
    ir_load     = 1'b0;
    set_illegal = 1'b0;
    imem_req    = 1'b0;
    pcen        = 1'b0;
    memtoreg    = 1'b0;
    pcsrc       = 1'b0;
    alusrc      = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    jump        = 1'b0;
    alucontrol  = 3'b000;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    halted      = 1'b0;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          pcen    = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_J: begin
            jump    = 1'b1;
            pcen    = 1'b1;
            state_n = S_FETCH;
          end
          OP_HALT: state_n = S_STOP;
          OP_RTYPE: begin
            if (bad_funct) begin
              set_illegal = 1'b1;
              state_n     = S_STOP;
            end else begin
              state_n = S_EXEC;
            end
          end
          OP_LW, OP_SW, OP_BEQ, OP_ADDI: state_n = S_EXEC;
          default: begin
            set_illegal = 1'b1;
            state_n     = S_STOP;
          end
        endcase
      end
      S_EXEC: begin
        case (op)
          OP_RTYPE: begin
            regdst     = 1'b1;
            alucontrol = alu_sel;
            state_n    = S_WB;
          end
          OP_ADDI: begin
            alusrc     = 1'b1;
            alucontrol = alu_sel;
            state_n    = S_WB;
          end
          OP_LW, OP_SW: begin
            alusrc     = 1'b1;
            alucontrol = alu_sel;
            state_n    = S_MEM;
          end
          OP_BEQ: begin
            pcsrc      = 1'b1;
            pcen       = zero;
            alucontrol = alu_sel;
            state_n    = S_FETCH;
          end
          default: state_n = S_STOP;
        endcase
      end
      S_MEM: begin
        dmem_req = is_mem_op(op);
        dmem_we  = (op == OP_SW);
        if (dmem_ready) state_n = (op == OP_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        regwrite = 1'b1;
        memtoreg = (op == OP_LW);
        regdst   = (op == OP_RTYPE);
        state_n  = S_FETCH;
      end
      S_STOP: halted = 1'b1;
      default: state_n = S_IDLE;
    endcase
  end

`ifdef CTRL_FSM_PERF_CNT_EN
  logic retire;

  // An instruction retires whenever control returns to FETCH from a later phase
  assign retire = (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB)
                  && (state_n == S_FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= 16'd0;
      instret_cnt <= 16'd0;
    end else begin
      if (state != S_IDLE && state != S_STOP) cycle_cnt <= cycle_cnt + 16'd1;
      if (retire) instret_cnt <= instret_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Cycle-by-cycle vector bench for ctrl_fsm: each record gives one cycle's inputs
// and the expected control strobes and instruction register.
module tb_ctrl_fsm;

  logic        clk;
  logic        reset;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        imem_req;
  logic [15:0] instr;
  logic        zero;
  logic        pcen, memtoreg, pcsrc, alusrc, regdst, regwrite, jump;
  logic [2:0]  alucontrol;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        halted, illegal;
`ifdef CTRL_FSM_PERF_CNT_EN
  logic [15:0] cycle_cnt, instret_cnt;
`endif

  ctrl_fsm #(.IWIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .imem_req   (imem_req),
    .instr      (instr),
    .zero       (zero),
    .pcen       (pcen),
    .memtoreg   (memtoreg),
    .pcsrc      (pcsrc),
    .alusrc     (alusrc),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .jump       (jump),
    .alucontrol (alucontrol),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .halted     (halted),
    .illegal    (illegal)
`ifdef CTRL_FSM_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed strobe order: imem_req pcen jump pcsrc alusrc regdst regwrite memtoreg
  // alucontrol[2:0] dmem_req dmem_we halted illegal
  localparam logic [14:0] IREQ = 15'h4000;
  localparam logic [14:0] PCEN = 15'h2000;
  localparam logic [14:0] JMP  = 15'h1000;
  localparam logic [14:0] PSRC = 15'h0800;
  localparam logic [14:0] ASRC = 15'h0400;
  localparam logic [14:0] RDST = 15'h0200;
  localparam logic [14:0] RWR  = 15'h0100;
  localparam logic [14:0] MTR  = 15'h0080;
  localparam logic [14:0] AADD = 15'h0020;
  localparam logic [14:0] ASUB = 15'h0060;
  localparam logic [14:0] AAND = 15'h0000;
  localparam logic [14:0] AOR  = 15'h0010;
  localparam logic [14:0] ASLT = 15'h0070;
  localparam logic [14:0] DREQ = 15'h0008;
  localparam logic [14:0] DWE  = 15'h0004;
  localparam logic [14:0] HLT  = 15'h0002;
  localparam logic [14:0] ILL  = 15'h0001;
  localparam logic [14:0] NONE = 15'h0000;

  typedef struct {
    logic        irdy;
    logic [15:0] rdata;
    logic        z;
    logic        drdy;
    logic [14:0] exp_ctrl;
    logic [15:0] exp_ir;
  } vec_t;

  vec_t vq[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   vidx   = 0;

  function automatic logic [14:0] outs();
    return {imem_req, pcen, jump, pcsrc, alusrc, regdst, regwrite, memtoreg,
            alucontrol, dmem_req, dmem_we, halted, illegal};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic v(input logic irdy, input logic [15:0] rdata, input logic z,
                   input logic drdy, input logic [14:0] ec, input logic [15:0] ei);
    vec_t t;
    t.irdy = irdy; t.rdata = rdata; t.z = z; t.drdy = drdy;
    t.exp_ctrl = ec; t.exp_ir = ei;
    vq.push_back(t);
  endtask

  task automatic apply_all();
    vec_t e;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      imem_ready = vq[i].irdy;
      imem_rdata = vq[i].rdata;
      zero       = vq[i].z;
      dmem_ready = vq[i].drdy;
      sb.push_back(vq[i]);
      #2;
      e = sb.pop_front();
      chk("ctrl", vidx, {17'd0, outs()}, {17'd0, e.exp_ctrl});
      chk("instr", vidx, {16'd0, instr}, {16'd0, e.exp_ir});
      vidx++;
    end
    vq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    imem_ready = 1'b0; imem_rdata = 16'h0; zero = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    #2;
    chk("reset_ctrl", vidx, {17'd0, outs()}, 32'd0);
    chk("reset_instr", vidx, {16'd0, instr}, 32'd0);
`ifdef CTRL_FSM_PERF_CNT_EN
    chk("reset_cnt", vidx, {cycle_cnt, instret_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; imem_ready = 1'b0; imem_rdata = 16'h0; zero = 1'b0; dmem_ready = 1'b0;

    // Main program: R add, LW with wait, BEQ taken/not, J, ADDI, R sub/and/or/slt, SW, bad funct
    do_reset();
    v(1, 16'h0000, 0, 0, NONE,        16'h0000);  // IDLE: ready ignored
    v(1, 16'h0000, 0, 0, IREQ | PCEN, 16'h0000);
    v(1, 16'hFFFF, 0, 0, NONE,        16'h0000);  // DECODE: ready ignored, ir stable
    v(0, 16'h0000, 0, 0, RDST | AADD, 16'h0000);
    v(0, 16'h0000, 0, 0, RWR | RDST,  16'h0000);
    v(1, 16'h1000, 0, 0, IREQ | PCEN, 16'h0000);
    v(0, 16'h0000, 0, 0, NONE,        16'h1000);
    v(0, 16'h0000, 0, 1, ASRC | AADD, 16'h1000);  // dmem_ready ignored without req
    v(0, 16'h0000, 0, 0, DREQ,        16'h1000);
    v(0, 16'h0000, 0, 0, DREQ,        16'h1000);
    v(0, 16'h0000, 0, 0, DREQ,        16'h1000);
    v(0, 16'h0000, 0, 1, DREQ,        16'h1000);
    v(0, 16'h0000, 0, 0, RWR | MTR,   16'h1000);
    v(0, 16'h3000, 0, 0, IREQ,        16'h1000);  // fetch wait cycle
    v(1, 16'h3000, 0, 0, IREQ | PCEN, 16'h1000);
    v(0, 16'h0000, 0, 0, NONE,        16'h3000);
    v(0, 16'h0000, 1, 0, PSRC | PCEN | ASUB, 16'h3000);
    v(1, 16'h3000, 0, 0, IREQ | PCEN, 16'h3000);
    v(0, 16'h0000, 0, 0, NONE,        16'h3000);
    v(0, 16'h0000, 0, 0, PSRC | ASUB, 16'h3000);
    v(1, 16'h5012, 0, 0, IREQ | PCEN, 16'h3000);
    v(0, 16'h0000, 0, 0, JMP | PCEN,  16'h5012);
    v(1, 16'h4000, 0, 0, IREQ | PCEN, 16'h5012);
    v(0, 16'h0000, 0, 0, NONE,        16'h4000);
    v(0, 16'h0000, 0, 0, ASRC | AADD, 16'h4000);
    v(0, 16'h0000, 0, 0, RWR,         16'h4000);
    v(1, 16'h0001, 0, 0, IREQ | PCEN, 16'h4000);
    v(0, 16'h0000, 0, 0, NONE,        16'h0001);
    v(0, 16'h0000, 0, 0, RDST | ASUB, 16'h0001);
    v(0, 16'h0000, 0, 0, RWR | RDST,  16'h0001);
    v(1, 16'h0002, 0, 0, IREQ | PCEN, 16'h0001);
    v(0, 16'h0000, 0, 0, NONE,        16'h0002);
    v(0, 16'h0000, 0, 0, RDST | AAND, 16'h0002);
    v(0, 16'h0000, 0, 0, RWR | RDST,  16'h0002);
    v(1, 16'h0003, 0, 0, IREQ | PCEN, 16'h0002);
    v(0, 16'h0000, 0, 0, NONE,        16'h0003);
    v(0, 16'h0000, 0, 0, RDST | AOR,  16'h0003);
    v(0, 16'h0000, 0, 0, RWR | RDST,  16'h0003);
    v(1, 16'h0004, 0, 0, IREQ | PCEN, 16'h0003);
    v(0, 16'h0000, 0, 0, NONE,        16'h0004);
    v(0, 16'h0000, 0, 0, RDST | ASLT, 16'h0004);
    v(0, 16'h0000, 0, 0, RWR | RDST,  16'h0004);
    v(1, 16'h2000, 0, 0, IREQ | PCEN, 16'h0004);
    v(0, 16'h0000, 0, 0, NONE,        16'h2000);
    v(0, 16'h0000, 0, 0, ASRC | AADD, 16'h2000);
    v(0, 16'h0000, 0, 1, DREQ | DWE,  16'h2000);
    v(1, 16'h0005, 0, 0, IREQ | PCEN, 16'h2000);
    v(1, 16'h0000, 0, 0, NONE,        16'h0005);
    v(1, 16'h1234, 0, 0, HLT | ILL,   16'h0005);
    v(0, 16'h1234, 0, 1, HLT | ILL,   16'h0005);
    v(1, 16'h1234, 0, 0, HLT | ILL,   16'h0005);
    apply_all();

    // Undefined opcode 0x7: sticky illegal, no further fetches
    do_reset();
    v(1, 16'h7000, 0, 0, NONE,        16'h0000);
    v(1, 16'h7000, 0, 0, IREQ | PCEN, 16'h0000);
    v(0, 16'h0000, 0, 0, NONE,        16'h7000);
    v(1, 16'h0000, 0, 0, HLT | ILL,   16'h7000);
    v(0, 16'h0000, 0, 0, HLT | ILL,   16'h7000);
    v(1, 16'h0000, 0, 1, HLT | ILL,   16'h7000);
    apply_all();

    // HALT stops without flagging illegal
    do_reset();
    v(1, 16'hF000, 0, 0, NONE,        16'h0000);
    v(1, 16'hF000, 0, 0, IREQ | PCEN, 16'h0000);
    v(1, 16'h0000, 0, 0, NONE,        16'hF000);
    v(1, 16'h0000, 0, 0, HLT,         16'hF000);
    v(1, 16'h0000, 0, 0, HLT,         16'hF000);
    apply_all();

    // J then SW stalled in MEM; asynchronous reset mid-access
    do_reset();
    v(1, 16'h5000, 0, 0, NONE,        16'h0000);
    v(1, 16'h5000, 0, 0, IREQ | PCEN, 16'h0000);
    v(0, 16'h0000, 0, 0, JMP | PCEN,  16'h5000);
    v(1, 16'h2000, 0, 0, IREQ | PCEN, 16'h5000);
    v(0, 16'h0000, 0, 0, NONE,        16'h2000);
    v(0, 16'h0000, 0, 0, ASRC | AADD, 16'h2000);
    v(0, 16'h0000, 0, 0, DREQ | DWE,  16'h2000);
    apply_all();
`ifdef CTRL_FSM_PERF_CNT_EN
    chk("cycle_cnt", vidx, {16'd0, cycle_cnt}, 32'd5);
    chk("instret_cnt", vidx, {16'd0, instret_cnt}, 32'd1);
`endif
    #1 reset = 1'b1;
    #1;
    chk("midmem_reset_ctrl", vidx, {17'd0, outs()}, 32'd0);
    chk("midmem_reset_instr", vidx, {16'd0, instr}, 32'd0);
`ifdef CTRL_FSM_PERF_CNT_EN
    chk("midmem_reset_cnt", vidx, {cycle_cnt, instret_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    v(0, 16'h0000, 0, 0, NONE,        16'h0000);  // back in IDLE
    v(0, 16'h0000, 0, 0, IREQ,        16'h0000);
    apply_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
